hba_mailbox: RTL and testbench
==============================

Name: hba_mailbox

Overview:
HBA bus slave (responder) providing two byte FIFOs between the HBA bus master and fabric logic.
- Down FIFO: bus writes, fabric reads.
- Up FIFO: fabric writes, bus reads.

It sits in a free slot alongside the other slaves, feeds hba_or_slaves, and raises slave_interrupt to the serial master's interrupt vector.

Parameters:
DBUS_WIDTH, 8, data bus width; also the FIFO word width
PERIPH_ADDR_WIDTH, 4, slot address width
REG_ADDR_WIDTH, 8, register address width
ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, full address bus width
PERIPH_ADDR, 0, slot number this block answers to
FIFO_DEPTH_LOG2, 4, log2 of each FIFO's depth (16 entries); must be at most 7

Ports:
hba_clk  in  1  clock
hba_reset  in  1  reset; one clock; reset is asynchronous and active-low
hba_rnw  in  1  1=read, 0=write
hba_select  in  1  transfer in progress
hba_abus  in  ADDR_WIDTH  address; upper PERIPH_ADDR_WIDTH bits = slot, lower REG_ADDR_WIDTH bits = register
hba_dbus  in  DBUS_WIDTH  write data
hba_dbus_slave  out  DBUS_WIDTH  read data; zero when not acking
hba_xferack_slave  out  1  transfer acknowledge; zero when inactive
slave_interrupt  out  1  level interrupt
mbox_down_data  out  DBUS_WIDTH  head of down FIFO
mbox_down_valid  out  1  down FIFO not empty
mbox_down_ready  in  1  fabric pops down FIFO when valid&ready
mbox_up_data  in  DBUS_WIDTH  fabric push data
mbox_up_valid  in  1  fabric push request
mbox_up_ready  out  1  up FIFO not full

Behaviour:
Register map (low REG_ADDR_WIDTH bits):
- 0 CTRL (R/W).
  - bit0: interrupt enable, up FIFO not empty.
  - bit1: interrupt enable, down FIFO empty.
  - other bits read 0.
- 1 STATUS (R; write 1 clears sticky bits).
  - bit0 down_full, bit1 down_empty, bit2 up_full, bit3 up_empty.
  - bit4 down_overflow (sticky), bit5 up_underflow (sticky).
- 2 DOWN_DATA (W): pushes into down FIFO. Reads return 0.
- 3 UP_DATA (R): pops from up FIFO. Writes are ignored.
- 4 DOWN_COUNT (R): down FIFO level, zero-extended.
- 5 UP_COUNT (R): up FIFO level, zero-extended.
- Any other register address: read returns 0, write ignored, still acked.

Bus FSM:
- IDLE → ACK when hba_select=1 and the slot field equals PERIPH_ADDR. The register read/write executes on that edge.
- In ACK, hba_xferack_slave=1 for exactly one cycle, and hba_dbus_slave carries the read data. Read data is 0 on writes.
- ACK → IDLE if hba_select=0; otherwise ACK → HOLD.
- HOLD → IDLE when hba_select=0. No new decode occurs in ACK or HOLD.
- Latency: ack one cycle after select is sampled.
- Non-matching slot: no ack; outputs stay 0.

FIFOs:
- Circular buffers with FIFO_DEPTH_LOG2-bit pointers and FIFO_DEPTH_LOG2+1-bit counts.
- Full/empty are evaluated on the current count.
- Bus push to a full down FIFO: data dropped, down_overflow set, transfer still acked.
- UP_DATA read of an empty up FIFO: returns 0, up_underflow set, pointers unchanged.
- Fabric push when full: not accepted, since mbox_up_ready=0.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Push when full and pop in the same cycle: push dropped, pop proceeds.
- Push when empty: mbox_down_valid or UP_COUNT becomes visible the next cycle (no fall-through).
- Pointer wrap at 2^FIFO_DEPTH_LOG2 is modulo.

Interrupt:
- slave_interrupt is registered: (CTRL[0] & !up_empty) | (CTRL[1] & down_empty).
- One-cycle delay from the underlying condition.

Reset (async assert, sync deassert at system level):
- FSM to IDLE.
- hba_xferack_slave=0, hba_dbus_slave=0, slave_interrupt=0.
- FIFOs empty, CTRL=0, sticky bits=0.
- mbox_down_valid=0, mbox_up_ready=1.
- Reset asserted mid-transfer drops xferack immediately; the transfer is lost.

Optional Feature:
MBOX_LOOPBACK_EN:
- With the macro defined:
  - CTRL bit2 enables loopback. While set, the down FIFO head is moved into the up FIFO one word per cycle whenever down is non-empty and up is not full.
  - mbox_down_valid=0, mbox_up_ready=0, and fabric push/pop are ignored.
- Without the macro: CTRL bit2 is not stored and reads 0; no loopback logic exists.

Test Plan:
- Reset then read STATUS → xferack 1 cycle after select; data 0x0A (both empty); mbox_up_ready=1; slave_interrupt=0.
- Write 0x11,0x22,0x33 to DOWN_DATA → DOWN_COUNT=3. Fabric with ready=1 receives 0x11,0x22,0x33 in order; then STATUS bit1=1.
- Fabric pushes 16 words 0x00..0x0F, plus a 17th while ready=0 → UP_COUNT=16. Sixteen UP_DATA reads return 0x00..0x0F; a 17th read returns 0 and sets STATUS bit5. Writing 0x20 to STATUS clears bit5.
- Write 17 bytes to DOWN_DATA with fabric ready=0 → DOWN_COUNT=16; STATUS bit4=1; first popped byte equals the first written byte.
- CTRL=0x01, fabric pushes one word → slave_interrupt rises 1 cycle later. Reading UP_DATA → interrupt falls 1 cycle after the pop.
- Access slot PERIPH_ADDR+1 → no ack, hba_dbus_slave=0. With hba_select held high for 3 cycles after ack → exactly one ack and one FIFO push.

Source files
------------

// File: rtl/hba_mailbox.sv
// HBA bus slave with a down FIFO (bus -> fabric) and an up FIFO (fabric -> bus).
// Optional loopback path (down head moved into up FIFO) is built when MBOX_LOOPBACK_EN is defined.
module hba_mailbox #(
   parameter int DBUS_WIDTH        = 8,
   parameter int PERIPH_ADDR_WIDTH = 4,
   parameter int REG_ADDR_WIDTH    = 8,
   parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
   parameter int PERIPH_ADDR       = 0,
   parameter int FIFO_DEPTH_LOG2   = 4
) (
   input  logic                  hba_clk,
   input  logic                  hba_reset,
   input  logic                  hba_rnw,
   input  logic                  hba_select,
   input  logic [ADDR_WIDTH-1:0] hba_abus,
   input  logic [DBUS_WIDTH-1:0] hba_dbus,
   output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
   output logic                  hba_xferack_slave,
   output logic                  slave_interrupt,
   output logic [DBUS_WIDTH-1:0] mbox_down_data,
   output logic                  mbox_down_valid,
   input  logic                  mbox_down_ready,
   input  logic [DBUS_WIDTH-1:0] mbox_up_data,
   input  logic                  mbox_up_valid,
   output logic                  mbox_up_ready
);

   localparam int PW    = FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PERIPH_ADDR_WIDTH-1:0] SLOT = PERIPH_ADDR_WIDTH'(PERIPH_ADDR);
   localparam logic [REG_ADDR_WIDTH-1:0] R_CTRL       = REG_ADDR_WIDTH'(0);
   localparam logic [REG_ADDR_WIDTH-1:0] R_STATUS     = REG_ADDR_WIDTH'(1);
   localparam logic [REG_ADDR_WIDTH-1:0] R_DOWN_DATA  = REG_ADDR_WIDTH'(2);
   localparam logic [REG_ADDR_WIDTH-1:0] R_UP_DATA    = REG_ADDR_WIDTH'(3);
   localparam logic [REG_ADDR_WIDTH-1:0] R_DOWN_COUNT = REG_ADDR_WIDTH'(4);
   localparam logic [REG_ADDR_WIDTH-1:0] R_UP_COUNT   = REG_ADDR_WIDTH'(5);
`ifdef MBOX_LOOPBACK_EN
   localparam int CTRL_W = 3;
`else
   localparam int CTRL_W = 2;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

   state_t                  state_q, state_d;
   logic [DBUS_WIDTH-1:0]   rdata_q, rdata_d;
   logic [CTRL_W-1:0]       ctrl_q;
   logic                    down_ovf_q, up_unf_q, irq_q;

   logic [DBUS_WIDTH-1:0]   down_mem [DEPTH];
   logic [DBUS_WIDTH-1:0]   up_mem   [DEPTH];
   logic [PW-1:0]           down_wr_q, down_rd_q, up_wr_q, up_rd_q;
   logic [CW-1:0]           down_cnt_q, up_cnt_q;

   logic [REG_ADDR_WIDTH-1:0] reg_addr;
   logic decode, bus_wr, bus_rd;
   logic down_empty, down_full, up_empty, up_full;
   logic down_push, down_pop, down_ovf_set;
   logic up_push, up_pop, up_unf_set, loop_move;
   logic [DBUS_WIDTH-1:0]   up_push_data;

   assign reg_addr   = hba_abus[REG_ADDR_WIDTH-1:0];
   assign decode     = (state_q == S_IDLE) && hba_select &&
                       (hba_abus[ADDR_WIDTH-1 -: PERIPH_ADDR_WIDTH] == SLOT);
   assign bus_wr     = decode && !hba_rnw;
   assign bus_rd     = decode && hba_rnw;

   assign down_empty = (down_cnt_q == '0);
   assign down_full  = (down_cnt_q == FULL_CNT);
   assign up_empty   = (up_cnt_q == '0);
   assign up_full    = (up_cnt_q == FULL_CNT);

`ifdef MBOX_LOOPBACK_EN
   // Loopback steals both fabric handshakes so the FIFOs only see the internal move.
   assign loop_move       = ctrl_q[2] && !down_empty && !up_full;
   assign mbox_down_valid = !down_empty && !ctrl_q[2];
   assign mbox_up_ready   = !up_full && !ctrl_q[2];
`else
   assign loop_move       = 1'b0;
   assign mbox_down_valid = !down_empty;
   assign mbox_up_ready   = !up_full;
`endif

   assign mbox_down_data = down_mem[down_rd_q];
   assign down_push      = bus_wr && (reg_addr == R_DOWN_DATA) && !down_full;
   assign down_ovf_set   = bus_wr && (reg_addr == R_DOWN_DATA) && down_full;
   assign down_pop       = (mbox_down_valid && mbox_down_ready) || loop_move;

   assign up_push        = (mbox_up_valid && mbox_up_ready) || loop_move;
   assign up_push_data   = loop_move ? mbox_down_data : mbox_up_data;
   assign up_pop         = bus_rd && (reg_addr == R_UP_DATA) && !up_empty;
   assign up_unf_set     = bus_rd && (reg_addr == R_UP_DATA) && up_empty;

   assign hba_xferack_slave = (state_q == S_ACK);
   assign hba_dbus_slave    = (state_q == S_ACK) ? rdata_q : '0;
   assign slave_interrupt   = irq_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (decode) state_d = S_ACK;
         S_ACK:   state_d = hba_select ? S_HOLD : S_IDLE;
         S_HOLD:  if (!hba_select) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rdata_d = '0;
      if (bus_rd) begin
         case (reg_addr)
            R_CTRL:       rdata_d = DBUS_WIDTH'(ctrl_q);
            R_STATUS:     rdata_d = DBUS_WIDTH'({up_unf_q, down_ovf_q, up_empty, up_full,
                                                 down_empty, down_full});
            R_UP_DATA:    if (!up_empty) rdata_d = up_mem[up_rd_q];
            R_DOWN_COUNT: rdata_d = DBUS_WIDTH'(down_cnt_q);
            R_UP_COUNT:   rdata_d = DBUS_WIDTH'(up_cnt_q);
            default:      rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge hba_clk or negedge hba_reset) begin
      if (!hba_reset) begin
         state_q    <= S_IDLE;
         rdata_q    <= '0;
         ctrl_q     <= '0;
         down_ovf_q <= 1'b0;
         up_unf_q   <= 1'b0;
         irq_q      <= 1'b0;
         down_wr_q  <= '0;
         down_rd_q  <= '0;
         down_cnt_q <= '0;
         up_wr_q    <= '0;
         up_rd_q    <= '0;
         up_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         irq_q   <= (ctrl_q[0] && !up_empty) || (ctrl_q[1] && down_empty);
         if (bus_wr && (reg_addr == R_CTRL)) ctrl_q <= hba_dbus[CTRL_W-1:0];
         // Set and write-one-clear never coincide: each needs its own transfer.
         if (down_ovf_set) down_ovf_q <= 1'b1;
         else if (bus_wr && (reg_addr == R_STATUS) && hba_dbus[4]) down_ovf_q <= 1'b0;
         if (up_unf_set) up_unf_q <= 1'b1;
         else if (bus_wr && (reg_addr == R_STATUS) && hba_dbus[5]) up_unf_q <= 1'b0;
         if (down_push) down_wr_q <= down_wr_q + PW'(1);
         if (down_pop)  down_rd_q <= down_rd_q + PW'(1);
         down_cnt_q <= down_cnt_q + CW'(down_push) - CW'(down_pop);
         if (up_push) up_wr_q <= up_wr_q + PW'(1);
         if (up_pop)  up_rd_q <= up_rd_q + PW'(1);
         up_cnt_q <= up_cnt_q + CW'(up_push) - CW'(up_pop);
      end
   end

   always_ff @(posedge hba_clk) begin
      if (down_push) down_mem[down_wr_q] <= hba_dbus;
      if (up_push)   up_mem[up_wr_q]     <= up_push_data;
   end

endmodule

// File: tb/tb_hba_mailbox.sv
// Self-checking bench for hba_mailbox: directed table, corner sequences, randomized run vs queue model.
module tb_hba_mailbox;

   localparam int DW = 8;
   localparam int AW = 12;
   localparam int DEPTH = 16;
   localparam logic [3:0] SLOT = 4'd0;

   logic          hba_clk = 1'b0;
   logic          hba_reset = 1'b0;
   logic          hba_rnw = 1'b0;
   logic          hba_select = 1'b0;
   logic [AW-1:0] hba_abus = '0;
   logic [DW-1:0] hba_dbus = '0;
   logic [DW-1:0] hba_dbus_slave;
   logic          hba_xferack_slave;
   logic          slave_interrupt;
   logic [DW-1:0] mbox_down_data;
   logic          mbox_down_valid;
   logic          mbox_down_ready = 1'b0;
   logic [DW-1:0] mbox_up_data = '0;
   logic          mbox_up_valid = 1'b0;
   logic          mbox_up_ready;

   hba_mailbox dut (
      .hba_clk          (hba_clk),
      .hba_reset        (hba_reset),
      .hba_rnw          (hba_rnw),
      .hba_select       (hba_select),
      .hba_abus         (hba_abus),
      .hba_dbus         (hba_dbus),
      .hba_dbus_slave   (hba_dbus_slave),
      .hba_xferack_slave(hba_xferack_slave),
      .slave_interrupt  (slave_interrupt),
      .mbox_down_data   (mbox_down_data),
      .mbox_down_valid  (mbox_down_valid),
      .mbox_down_ready  (mbox_down_ready),
      .mbox_up_data     (mbox_up_data),
      .mbox_up_valid    (mbox_up_valid),
      .mbox_up_ready    (mbox_up_ready)
   );

   always #5 hba_clk = ~hba_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: two byte queues plus the few architectural bits.
   logic [7:0] down_q[$];
   logic [7:0] up_q[$];
   logic [1:0] m_ctrl = 2'b00;
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;
   logic       m_irq = 1'b0;

   typedef struct {
      logic       rnw;
      logic [7:0] ra;
      logic [7:0] wd;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      down_q.delete();
      up_q.delete();
      m_ctrl = 2'b00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_irq  = 1'b0;
   endtask

   function automatic logic [7:0] status_val();
      return {2'b00, m_unf, m_ovf, up_q.size() == 0, up_q.size() == DEPTH,
              down_q.size() == 0, down_q.size() == DEPTH};
   endfunction

   // One clock edge: predict from pre-edge state and driven inputs, then compare after the edge.
   task automatic step(input bit decode, output logic [7:0] rd_act);
      int         dn = down_q.size();
      int         un = up_q.size();
      bit         fab_pop = mbox_down_ready && (dn > 0);
      bit         fab_push = mbox_up_valid && (un < DEPTH);
      logic [7:0] push_data = mbox_up_data;
      logic [7:0] wdata = hba_dbus;
      bit         bus_push = 1'b0;
      bit         bus_pop = 1'b0;
      logic [7:0] exp_rd = 8'h00;
      bit         irq_next = (m_ctrl[0] && un > 0) || (m_ctrl[1] && dn == 0);
      if (decode) begin
         case (hba_abus[7:0])
            8'd0: if (hba_rnw) exp_rd = {6'b0, m_ctrl}; else m_ctrl = wdata[1:0];
            8'd1: if (hba_rnw) exp_rd = status_val();
                  else begin
                     if (wdata[4]) m_ovf = 1'b0;
                     if (wdata[5]) m_unf = 1'b0;
                  end
            8'd2: if (!hba_rnw) begin
                     if (dn == DEPTH) m_ovf = 1'b1; else bus_push = 1'b1;
                  end
            8'd3: if (hba_rnw) begin
                     if (un == 0) m_unf = 1'b1;
                     else begin exp_rd = up_q[0]; bus_pop = 1'b1; end
                  end
            8'd4: if (hba_rnw) exp_rd = 8'(dn);
            8'd5: if (hba_rnw) exp_rd = 8'(un);
            default: exp_rd = 8'h00;
         endcase
      end
      @(posedge hba_clk);
      #1;
      if (fab_pop)  void'(down_q.pop_front());
      if (bus_push) down_q.push_back(wdata);
      if (bus_pop)  void'(up_q.pop_front());
      if (fab_push) up_q.push_back(push_data);
      m_irq = irq_next;
      rd_act = hba_dbus_slave;
      check("xferack", hba_xferack_slave, decode);
      check("rdata", hba_dbus_slave, decode ? exp_rd : 8'h00);
      check("down_valid", mbox_down_valid, down_q.size() > 0);
      if (down_q.size() > 0) check("down_data", mbox_down_data, down_q[0]);
      check("up_ready", mbox_up_ready, up_q.size() < DEPTH);
      check("irq", slave_interrupt, m_irq);
   endtask

   task automatic bus(input logic rnw, input logic [7:0] ra, input logic [7:0] wd,
                      output logic [7:0] rd);
      logic [7:0] dummy;
      hba_select = 1'b1;
      hba_rnw    = rnw;
      hba_abus   = {SLOT, ra};
      hba_dbus   = wd;
      step(1'b1, rd);
      hba_select = 1'b0;
      step(1'b0, dummy);
   endtask

   task automatic idle(input int n);
      logic [7:0] dummy;
      for (int i = 0; i < n; i++) step(1'b0, dummy);
   endtask

   initial begin
      logic [7:0] rd;
      logic [3:0] slot;
      bit         dec, last_dec;
      int         pop_bias, push_bias;

      tbl[0]  = '{1'b1, 8'd1, 8'h00, 8'h0A};
      tbl[1]  = '{1'b1, 8'd0, 8'h00, 8'h00};
      tbl[2]  = '{1'b0, 8'd0, 8'hFE, 8'h00};
      tbl[3]  = '{1'b1, 8'd0, 8'h00, 8'h02};
      tbl[4]  = '{1'b0, 8'd0, 8'h00, 8'h00};
      tbl[5]  = '{1'b0, 8'd2, 8'h11, 8'h00};
      tbl[6]  = '{1'b0, 8'd2, 8'h22, 8'h00};
      tbl[7]  = '{1'b0, 8'd2, 8'h33, 8'h00};
      tbl[8]  = '{1'b1, 8'd4, 8'h00, 8'h03};
      tbl[9]  = '{1'b1, 8'd5, 8'h00, 8'h00};
      tbl[10] = '{1'b1, 8'd2, 8'h00, 8'h00};
      tbl[11] = '{1'b1, 8'd9, 8'h00, 8'h00};
      tbl[12] = '{1'b0, 8'd3, 8'h55, 8'h00};
      tbl[13] = '{1'b1, 8'd1, 8'h00, 8'h08};

      model_reset();
      repeat (3) @(posedge hba_clk);
      #1;
      check("rst_xferack", hba_xferack_slave, 1'b0);
      check("rst_dbus", hba_dbus_slave, 8'h00);
      check("rst_irq", slave_interrupt, 1'b0);
      check("rst_down_valid", mbox_down_valid, 1'b0);
      check("rst_up_ready", mbox_up_ready, 1'b1);
      hba_reset = 1'b1;
      idle(2);

      // Acknowledge must not appear before the decode edge.
      hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = {SLOT, 8'd1};
      check("ack_latency", hba_xferack_slave, 1'b0);
      hba_select = 1'b0;

      for (int i = 0; i < 14; i++) begin
         bus(tbl[i].rnw, tbl[i].ra, tbl[i].wd, rd);
         if (tbl[i].rnw) check($sformatf("tbl%0d", i), rd, tbl[i].exp);
      end

      mbox_down_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("fabric_pop", mbox_down_data, 8'h11 * (i + 1));
         idle(1);
      end
      mbox_down_ready = 1'b0;
      bus(1'b1, 8'd1, 8'h00, rd);
      check("status_drained", rd, 8'h0A);

      // Up FIFO fill, overflow attempt, drain and underflow.
      mbox_up_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         mbox_up_data = 8'(i);
         idle(1);
      end
      check("up_ready_full", mbox_up_ready, 1'b0);
      mbox_up_data = 8'h99;
      idle(1);
      mbox_up_valid = 1'b0;
      bus(1'b1, 8'd5, 8'h00, rd);
      check("up_count16", rd, 8'h10);
      for (int i = 0; i < 16; i++) begin
         bus(1'b1, 8'd3, 8'h00, rd);
         check("up_data", rd, 8'(i));
      end
      bus(1'b1, 8'd3, 8'h00, rd);
      check("up_underflow_rd", rd, 8'h00);
      bus(1'b1, 8'd1, 8'h00, rd);
      check("status_unf", rd, 8'h2A);
      bus(1'b0, 8'd1, 8'h20, rd);
      bus(1'b1, 8'd1, 8'h00, rd);
      check("status_unf_clr", rd, 8'h0A);

      // Down FIFO overflow with fabric stalled.
      for (int i = 0; i < 17; i++) bus(1'b0, 8'd2, 8'(8'h40 + i), rd);
      bus(1'b1, 8'd4, 8'h00, rd);
      check("down_count16", rd, 8'h10);
      bus(1'b1, 8'd1, 8'h00, rd);
      check("status_ovf", rd, 8'h19);
      mbox_down_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("ovf_pop_order", mbox_down_data, 8'(8'h40 + i));
         idle(1);
      end
      mbox_down_ready = 1'b0;
      bus(1'b0, 8'd1, 8'h10, rd);
      bus(1'b1, 8'd1, 8'h00, rd);
      check("status_ovf_clr", rd, 8'h0A);

      // Interrupt on up-not-empty.
      bus(1'b0, 8'd0, 8'h01, rd);
      mbox_up_valid = 1'b1; mbox_up_data = 8'hA5;
      idle(1);
      mbox_up_valid = 1'b0;
      check("irq_not_yet", slave_interrupt, 1'b0);
      idle(1);
      check("irq_rise", slave_interrupt, 1'b1);
      bus(1'b1, 8'd3, 8'h00, rd);
      check("irq_pop_data", rd, 8'hA5);
      check("irq_fall", slave_interrupt, 1'b0);
      bus(1'b0, 8'd0, 8'h00, rd);

      // Foreign slot: no acknowledge, bus stays zero.
      hba_select = 1'b1; hba_rnw = 1'b0; hba_abus = {SLOT + 4'd1, 8'd2}; hba_dbus = 8'h66;
      step(1'b0, rd);
      check("foreign_ack", hba_xferack_slave, 1'b0);
      hba_select = 1'b0;
      idle(1);

      // Select held for three cycles past the ack: single push only.
      hba_select = 1'b1; hba_rnw = 1'b0; hba_abus = {SLOT, 8'd2}; hba_dbus = 8'h77;
      step(1'b1, rd);
      for (int i = 0; i < 3; i++) step(1'b0, rd);
      hba_select = 1'b0;
      idle(1);
      bus(1'b1, 8'd4, 8'h00, rd);
      check("hold_single_push", rd, 8'h01);
      mbox_down_ready = 1'b1;
      idle(1);
      mbox_down_ready = 1'b0;

      // Randomized traffic on both sides against the model.
      last_dec = 1'b0;
      pop_bias = 2;
      push_bias = 2;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) begin
            pop_bias  = $urandom_range(0, 4);
            push_bias = $urandom_range(0, 4);
         end
         mbox_down_ready = ($urandom_range(0, 3) < pop_bias);
         mbox_up_valid   = ($urandom_range(0, 3) < push_bias);
         mbox_up_data    = 8'($urandom);
         dec = 1'b0;
         if (!last_dec && $urandom_range(0, 1) == 1) begin
            slot = ($urandom_range(0, 7) == 0) ? SLOT + 4'd1 : SLOT;
            hba_select = 1'b1;
            hba_rnw    = 1'($urandom_range(0, 1));
            hba_abus   = {slot, 8'($urandom_range(0, 7))};
            hba_dbus   = 8'($urandom);
            dec        = (slot == SLOT);
         end else begin
            hba_select = 1'b0;
         end
         step(dec, rd);
         last_dec = dec;
      end
      hba_select = 1'b0;
      mbox_down_ready = 1'b0;
      mbox_up_valid = 1'b0;
      idle(1);

      // Reset in the middle of an acknowledged transfer.
      hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = {SLOT, 8'd1};
      step(1'b1, rd);
      hba_reset = 1'b0;
      #1;
      check("midrst_xferack", hba_xferack_slave, 1'b0);
      check("midrst_dbus", hba_dbus_slave, 8'h00);
      check("midrst_down_valid", mbox_down_valid, 1'b0);
      check("midrst_up_ready", mbox_up_ready, 1'b1);
      check("midrst_irq", slave_interrupt, 1'b0);
      hba_select = 1'b0;
      model_reset();
      @(posedge hba_clk);
      #1;
      hba_reset = 1'b1;
      idle(1);
      bus(1'b1, 8'd1, 8'h00, rd);
      check("post_rst_status", rd, 8'h0A);
      bus(1'b1, 8'd0, 8'h00, rd);
      check("post_rst_ctrl", rd, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
